// File: rtl/rs_age_queue_if.sv
// Issue / write-back / dispatch bundle of the age-ordered reservation station.
// The master drives issue, broadcast, flush and execution-side ready; the
// station (slave) drives the dispatch payload and its occupancy status.
interface rs_age_queue_if #(
   parameter int DEPTH  = 16,
   parameter int ROB_W  = 6,
   parameter int NUM_WB = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                    rdy;
   logic                    flush;
   logic                    in_valid;
   logic [5:0]              in_opcode;
   logic [31:0]             in_val1;
   logic [31:0]             in_val2;
   logic [ROB_W-1:0]        in_dep1;
   logic [ROB_W-1:0]        in_dep2;
   logic                    in_has_dep1;
   logic                    in_has_dep2;
   logic [ROB_W-1:0]        in_rob;
   logic [31:0]             in_imm;
   logic [31:0]             in_pc;
   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*ROB_W-1:0] wb_rob;
   logic [NUM_WB*32-1:0]    wb_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [5:0]              out_opcode;
   logic [31:0]             out_val1;
   logic [31:0]             out_val2;
   logic [31:0]             out_imm;
   logic [31:0]             out_pc;
   logic [ROB_W-1:0]        out_rob;
   logic                    full;
   logic [CNT_W-1:0]        count;

   modport master (
      output rdy, flush, in_valid, in_opcode, in_val1, in_val2, in_dep1, in_dep2,
             in_has_dep1, in_has_dep2, in_rob, in_imm, in_pc,
             wb_valid, wb_rob, wb_data, out_ready,
      input  out_valid, out_opcode, out_val1, out_val2, out_imm, out_pc, out_rob,
             full, count
   );

   modport slave (
      input  rdy, flush, in_valid, in_opcode, in_val1, in_val2, in_dep1, in_dep2,
             in_has_dep1, in_has_dep2, in_rob, in_imm, in_pc,
             wb_valid, wb_rob, wb_data, out_ready,
      output out_valid, out_opcode, out_val1, out_val2, out_imm, out_pc, out_rob,
             full, count
   );
endinterface

// File: rtl/rs_age_queue.sv
// Age-ordered reservation station feeding one execution unit. Entries wake up
// from broadcast write-back channels; the oldest ready entry is dispatched
// through a registered valid/ready output stage. Age is kept as a per-entry
// row of "older than me" bits, so selection needs no priority by slot index.
module rs_age_queue #(
   parameter int DEPTH  = 16,
   parameter int ROB_W  = 6,
   parameter int NUM_WB = 2
) (
   input logic           clk,
   input logic           rst,
   rs_age_queue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] hd1_q, hd1_d, hd2_q, hd2_d;
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];
   logic [31:0]      val1_q  [DEPTH];
   logic [31:0]      val1_d  [DEPTH];
   logic [31:0]      val2_q  [DEPTH];
   logic [31:0]      val2_d  [DEPTH];
   logic [5:0]       opcode_q [DEPTH];
   logic [ROB_W-1:0] dep1_q [DEPTH];
   logic [ROB_W-1:0] dep2_q [DEPTH];
   logic [ROB_W-1:0] rob_q  [DEPTH];
   logic [31:0]      imm_q  [DEPTH];
   logic [31:0]      pc_q   [DEPTH];

   logic             out_valid_q, out_valid_d;
   logic [5:0]       out_opcode_q, out_opcode_d;
   logic [31:0]      out_val1_q, out_val1_d, out_val2_q, out_val2_d;
   logic [31:0]      out_imm_q, out_imm_d, out_pc_q, out_pc_d;
   logic [ROB_W-1:0] out_rob_q, out_rob_d;

   logic [DEPTH-1:0] ready_vec, sel_vec, disp_mask, ins_mask;
   logic [DEPTH-1:0] wk1_hit, wk2_hit;
   logic [31:0]      wk1_data [DEPTH];
   logic [31:0]      wk2_data [DEPTH];
   logic             byp1_hit, byp2_hit;
   logic [31:0]      byp1_data, byp2_data;
   logic             ins_found, do_disp, do_ins;
   logic [IDX_W-1:0] ins_idx, sel_idx;
   logic [CNT_W-1:0] busy_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_sel
         assign ready_vec[gi] = busy_q[gi] & ~hd1_q[gi] & ~hd2_q[gi];
         // oldest ready entry: no ready entry appears in its older row
         assign sel_vec[gi]   = ready_vec[gi] & ~|(ready_vec & older_q[gi]);
      end
   endgenerate

   // Broadcast matching for stored operands and the incoming issue; scanning
   // channels high-to-low lets the lowest matching channel win.
   always_comb begin
      byp1_hit  = 1'b0;
      byp2_hit  = 1'b0;
      byp1_data = '0;
      byp2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wk1_hit[i]  = 1'b0;
         wk2_hit[i]  = 1'b0;
         wk1_data[i] = '0;
         wk2_data[i] = '0;
      end
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (bus.wb_valid[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (bus.wb_rob[k*ROB_W +: ROB_W] == dep1_q[i]) begin
                  wk1_hit[i]  = 1'b1;
                  wk1_data[i] = bus.wb_data[k*32 +: 32];
               end
               if (bus.wb_rob[k*ROB_W +: ROB_W] == dep2_q[i]) begin
                  wk2_hit[i]  = 1'b1;
                  wk2_data[i] = bus.wb_data[k*32 +: 32];
               end
            end
            if (bus.wb_rob[k*ROB_W +: ROB_W] == bus.in_dep1) begin
               byp1_hit  = 1'b1;
               byp1_data = bus.wb_data[k*32 +: 32];
            end
            if (bus.wb_rob[k*ROB_W +: ROB_W] == bus.in_dep2) begin
               byp2_hit  = 1'b1;
               byp2_data = bus.wb_data[k*32 +: 32];
            end
         end
      end
   end

   // Lowest free slot, index of the selected entry, and occupancy count.
   always_comb begin
      ins_found = 1'b0;
      ins_idx   = '0;
      sel_idx   = '0;
      busy_cnt  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            ins_found = 1'b1;
            ins_idx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_vec[i]) sel_idx = IDX_W'(i);
         busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
      end
   end

   assign do_disp   = (|sel_vec) && (!out_valid_q || bus.out_ready);
   assign do_ins    = bus.in_valid && ins_found && !bus.flush;
   assign disp_mask = do_disp ? sel_vec : '0;
   assign ins_mask  = do_ins ? ({{(DEPTH-1){1'b0}}, 1'b1} << ins_idx) : '0;

   // Entry next state: dispatch frees a slot and drops it from every age row,
   // insert records all surviving busy entries as older, wakeup clears deps.
   always_comb begin
      busy_d = (busy_q & ~disp_mask) | ins_mask;
      hd1_d  = hd1_q & ~wk1_hit;
      hd2_d  = hd2_q & ~wk2_hit;
      for (int i = 0; i < DEPTH; i++) begin
         val1_d[i]  = (hd1_q[i] && wk1_hit[i]) ? wk1_data[i] : val1_q[i];
         val2_d[i]  = (hd2_q[i] && wk2_hit[i]) ? wk2_data[i] : val2_q[i];
         older_d[i] = older_q[i] & ~disp_mask;
         if (ins_mask[i]) begin
            hd1_d[i]   = bus.in_has_dep1 & ~byp1_hit;
            hd2_d[i]   = bus.in_has_dep2 & ~byp2_hit;
            val1_d[i]  = (bus.in_has_dep1 && byp1_hit) ? byp1_data : bus.in_val1;
            val2_d[i]  = (bus.in_has_dep2 && byp2_hit) ? byp2_data : bus.in_val2;
            older_d[i] = busy_q & ~disp_mask;
         end
      end
      if (bus.flush) begin
         busy_d = '0;
         hd1_d  = '0;
         hd2_d  = '0;
         for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
      end
   end

   // Entry control state; rdy low freezes everything except reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         hd1_q  <= '0;
         hd2_q  <= '0;
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else if (bus.rdy) begin
         busy_q <= busy_d;
         hd1_q  <= hd1_d;
         hd2_q  <= hd2_d;
         for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
      end
   end

   // Entry payload: operands follow wakeup, the rest is written on insert only.
   always_ff @(posedge clk) begin
      if (!rst && bus.rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            val1_q[i] <= val1_d[i];
            val2_q[i] <= val2_d[i];
            if (ins_mask[i]) begin
               opcode_q[i] <= bus.in_opcode;
               dep1_q[i]   <= bus.in_dep1;
               dep2_q[i]   <= bus.in_dep2;
               rob_q[i]    <= bus.in_rob;
               imm_q[i]    <= bus.in_imm;
               pc_q[i]     <= bus.in_pc;
            end
         end
      end
   end

   // Output stage: load on dispatch, drop valid when consumed with nothing new.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_val1_d   = out_val1_q;
      out_val2_d   = out_val2_q;
      out_imm_d    = out_imm_q;
      out_pc_d     = out_pc_q;
      out_rob_d    = out_rob_q;
      if (do_disp) begin
         out_valid_d  = 1'b1;
         out_opcode_d = opcode_q[sel_idx];
         out_val1_d   = val1_q[sel_idx];
         out_val2_d   = val2_q[sel_idx];
         out_imm_d    = imm_q[sel_idx];
         out_pc_d     = pc_q[sel_idx];
         out_rob_d    = rob_q[sel_idx];
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (bus.flush) out_valid_d = 1'b0;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_val1_q   <= '0;
         out_val2_q   <= '0;
         out_imm_q    <= '0;
         out_pc_q     <= '0;
         out_rob_q    <= '0;
      end else if (bus.rdy) begin
         out_valid_q  <= out_valid_d;
         out_opcode_q <= out_opcode_d;
         out_val1_q   <= out_val1_d;
         out_val2_q   <= out_val2_d;
         out_imm_q    <= out_imm_d;
         out_pc_q     <= out_pc_d;
         out_rob_q    <= out_rob_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_opcode = out_opcode_q;
   assign bus.out_val1   = out_val1_q;
   assign bus.out_val2   = out_val2_q;
   assign bus.out_imm    = out_imm_q;
   assign bus.out_pc     = out_pc_q;
   assign bus.out_rob    = out_rob_q;
   assign bus.count      = busy_cnt;
   // one slot of margin for the issue unit's one-cycle reaction
   assign bus.full       = (busy_cnt >= CNT_W'(DEPTH - 1));
endmodule

// File: tb/tb_rs_age_queue.sv
// Directed bench for rs_age_queue: a table of per-cycle vectors plus short
// hand-written sequences for backpressure and the full threshold.
module tb_rs_age_queue;
   localparam int DEPTH  = 8;
   localparam int ROB_W  = 6;
   localparam int NUM_WB = 2;

   typedef struct {
      logic        iv;
      logic [5:0]  rob;
      logic [31:0] v1, v2;
      logic        h1;
      logic [5:0]  d1;
      logic        h2;
      logic [5:0]  d2;
      logic [1:0]  wbv;
      logic [5:0]  wr0, wr1;
      logic [31:0] wd0, wd1;
      logic        ordy, fl, rd;
      logic        e_ov;
      logic [5:0]  e_rob;
      logic [31:0] e_v1, e_v2;
      int          e_cnt;
      logic        e_full;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   rs_age_queue_if #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_WB(NUM_WB)) bus ();

   rs_age_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_WB(NUM_WB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic vec_t nop();
      vec_t v;
      v.iv = 1'b0; v.rob = '0; v.v1 = '0; v.v2 = '0;
      v.h1 = 1'b0; v.d1 = '0; v.h2 = 1'b0; v.d2 = '0;
      v.wbv = '0; v.wr0 = '0; v.wr1 = '0; v.wd0 = '0; v.wd1 = '0;
      v.ordy = 1'b1; v.fl = 1'b0; v.rd = 1'b1;
      v.e_ov = 1'b0; v.e_rob = '0; v.e_v1 = '0; v.e_v2 = '0; v.e_cnt = 0; v.e_full = 1'b0;
      return v;
   endfunction

   function automatic vec_t ins(input vec_t b, input logic [5:0] rob, input logic [31:0] v1,
                                input logic [31:0] v2, input logic h1, input logic [5:0] d1,
                                input logic h2, input logic [5:0] d2);
      vec_t v = b;
      v.iv = 1'b1; v.rob = rob; v.v1 = v1; v.v2 = v2;
      v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
      return v;
   endfunction

   function automatic vec_t wb(input vec_t b, input int ch, input logic [5:0] r, input logic [31:0] d);
      vec_t v = b;
      v.wbv[ch] = 1'b1;
      if (ch == 0) begin v.wr0 = r; v.wd0 = d; end
      else begin v.wr1 = r; v.wd1 = d; end
      return v;
   endfunction

   function automatic vec_t ctl(input vec_t b, input logic ordy, input logic fl, input logic rd);
      vec_t v = b;
      v.ordy = ordy; v.fl = fl; v.rd = rd;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t b, input logic ov, input logic [5:0] rob,
                               input logic [31:0] v1, input logic [31:0] v2, input int cnt,
                               input logic full);
      vec_t v = b;
      v.e_ov = ov; v.e_rob = rob; v.e_v1 = v1; v.e_v2 = v2; v.e_cnt = cnt; v.e_full = full;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
   endtask

   // opcode, immediate and pc are derived from the rob tag so routing is checked
   task automatic drive(input vec_t v);
      bus.rdy         = v.rd;
      bus.flush       = v.fl;
      bus.in_valid    = v.iv;
      bus.in_rob      = v.rob;
      bus.in_opcode   = ~v.rob;
      bus.in_imm      = 32'(v.rob) + 32'd1000;
      bus.in_pc       = 32'h1000 + 32'(v.rob) * 4;
      bus.in_val1     = v.v1;
      bus.in_val2     = v.v2;
      bus.in_has_dep1 = v.h1;
      bus.in_dep1     = v.d1;
      bus.in_has_dep2 = v.h2;
      bus.in_dep2     = v.d2;
      bus.wb_valid    = v.wbv;
      bus.wb_rob      = {v.wr1, v.wr0};
      bus.wb_data     = {v.wd1, v.wd0};
      bus.out_ready   = v.ordy;
   endtask

   task automatic run(input int idx, input vec_t v);
      drive(v);
      @(posedge clk);
      #1;
      $display("vec %0d: in_valid=%0b rob=%0d flush=%0b rdy=%0b -> out_valid=%0b out_rob=%0d val1=0x%0h val2=0x%0h count=%0d full=%0b",
               idx, v.iv, v.rob, v.fl, v.rd, bus.out_valid, bus.out_rob, bus.out_val1,
               bus.out_val2, bus.count, bus.full);
      chk("out_valid", idx, 32'(bus.out_valid), 32'(v.e_ov));
      chk("count", idx, 32'(bus.count), 32'(v.e_cnt));
      chk("full", idx, 32'(bus.full), 32'(v.e_full));
      if (v.e_ov) begin
         chk("out_rob", idx, 32'(bus.out_rob), 32'(v.e_rob));
         chk("out_val1", idx, bus.out_val1, v.e_v1);
         chk("out_val2", idx, bus.out_val2, v.e_v2);
         chk("out_opcode", idx, 32'(bus.out_opcode), 32'(6'(~v.e_rob)));
         chk("out_imm", idx, bus.out_imm, 32'(v.e_rob) + 32'd1000);
         chk("out_pc", idx, bus.out_pc, 32'h1000 + 32'(v.e_rob) * 4);
      end
   endtask

   initial begin
      vec_t n;
      n = nop();
      // single ready insert, dispatched one edge later
      vecs.push_back(ex(ins(n, 5, 32'h3, 32'h4, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(n, 1, 5, 32'h3, 32'h4, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // pending rob1 overtaken by ready rob2, then woken on channel 1
      vecs.push_back(ex(ins(n, 1, 32'h0, 32'h11, 1, 9, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ins(n, 2, 32'h22, 32'h33, 0, 0, 0, 0), 0, 0, 0, 0, 2, 0));
      vecs.push_back(ex(n, 1, 2, 32'h22, 32'h33, 1, 0));
      vecs.push_back(ex(wb(n, 1, 9, 32'hAB), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(n, 1, 1, 32'hAB, 32'h11, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // three entries pending on tag 12, dispatched in age order
      vecs.push_back(ex(ins(n, 3, 32'h0, 32'h30, 1, 12, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ins(n, 4, 32'h40, 32'h0, 0, 0, 1, 12), 0, 0, 0, 0, 2, 0));
      vecs.push_back(ex(ins(n, 7, 32'h0, 32'h0, 1, 12, 1, 12), 0, 0, 0, 0, 3, 0));
      vecs.push_back(ex(wb(n, 0, 12, 32'hC0), 0, 0, 0, 0, 3, 0));
      vecs.push_back(ex(n, 1, 3, 32'hC0, 32'h30, 2, 0));
      vecs.push_back(ex(n, 1, 4, 32'h40, 32'hC0, 1, 0));
      vecs.push_back(ex(n, 1, 7, 32'hC0, 32'hC0, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // same again with C landing in slot 0 after a blocker leaves it
      vecs.push_back(ex(ins(n, 20, 32'h0, 32'h0, 1, 30, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ins(n, 3, 32'h0, 32'h31, 1, 12, 0, 0), 0, 0, 0, 0, 2, 0));
      vecs.push_back(ex(ins(n, 4, 32'h0, 32'h41, 1, 12, 0, 0), 0, 0, 0, 0, 3, 0));
      vecs.push_back(ex(wb(n, 1, 30, 32'h99), 0, 0, 0, 0, 3, 0));
      vecs.push_back(ex(n, 1, 20, 32'h99, 32'h0, 2, 0));
      vecs.push_back(ex(ins(n, 7, 32'h0, 32'h71, 1, 12, 0, 0), 0, 0, 0, 0, 3, 0));
      // both channels match: channel 0 data must win
      vecs.push_back(ex(wb(wb(n, 0, 12, 32'hC1), 1, 12, 32'hDD), 0, 0, 0, 0, 3, 0));
      vecs.push_back(ex(n, 1, 3, 32'hC1, 32'h31, 2, 0));
      vecs.push_back(ex(n, 1, 4, 32'hC1, 32'h41, 1, 0));
      vecs.push_back(ex(n, 1, 7, 32'hC1, 32'h71, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // insert bypass on operand 2
      vecs.push_back(ex(wb(ins(n, 8, 32'h10, 32'hFF, 0, 0, 1, 6), 0, 6, 32'h55), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(n, 1, 8, 32'h10, 32'h55, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // flush with five busy entries, out_valid high and a concurrent insert
      vecs.push_back(ex(ins(n, 10, 32'hA, 32'hB, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ins(n, 11, 32'h0, 32'h0, 1, 40, 0, 0), 1, 10, 32'hA, 32'hB, 1, 0));
      for (int r = 12; r <= 15; r++)
         vecs.push_back(ex(ctl(ins(n, 6'(r), 32'h0, 32'h0, 1, 40, 0, 0), 0, 0, 1),
                           1, 10, 32'hA, 32'hB, r - 10, 0));
      vecs.push_back(ex(ctl(ins(n, 16, 32'h1, 32'h2, 0, 0, 0, 0), 0, 1, 1), 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(wb(n, 0, 40, 32'h1), 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));
      // rdy low freezes insert, dispatch and output consumption
      vecs.push_back(ex(ctl(ins(n, 21, 32'h5, 32'h6, 0, 0, 0, 0), 1, 0, 0), 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(ins(n, 21, 32'h5, 32'h6, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ctl(n, 1, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(ctl(wb(n, 0, 21, 32'h7), 1, 0, 0), 0, 0, 0, 0, 1, 0));
      vecs.push_back(ex(n, 1, 21, 32'h5, 32'h6, 0, 0));
      vecs.push_back(ex(ctl(n, 1, 0, 0), 1, 21, 32'h5, 32'h6, 0, 0));
      vecs.push_back(ex(n, 0, 0, 0, 0, 0, 0));

      // reset state
      drive(n);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", -1, 32'(bus.out_valid), 32'd0);
      chk("rst_count", -1, 32'(bus.count), 32'd0);
      chk("rst_full", -1, 32'(bus.full), 32'd0);
      chk("rst_out_rob", -1, 32'(bus.out_rob), 32'd0);
      chk("rst_out_val1", -1, bus.out_val1, 32'd0);
      chk("rst_out_pc", -1, bus.out_pc, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) run(i, vecs[i]);

      // backpressure: three ready entries with out_ready low
      run(100, ex(ctl(ins(n, 31, 32'd31, 32'd1, 0, 0, 0, 0), 0, 0, 1), 0, 0, 0, 0, 1, 0));
      run(101, ex(ctl(ins(n, 32, 32'd32, 32'd1, 0, 0, 0, 0), 0, 0, 1), 1, 31, 32'd31, 32'd1, 1, 0));
      run(102, ex(ctl(ins(n, 33, 32'd33, 32'd1, 0, 0, 0, 0), 0, 0, 1), 1, 31, 32'd31, 32'd1, 2, 0));
      for (int c = 0; c < 3; c++)
         run(103 + c, ex(ctl(n, 0, 0, 1), 1, 31, 32'd31, 32'd1, 2, 0));
      run(106, ex(n, 1, 32, 32'd32, 32'd1, 1, 0));
      run(107, ex(n, 1, 33, 32'd33, 32'd1, 0, 0));
      run(108, ex(n, 0, 0, 0, 0, 0, 0));

      // fill with pending entries up to and past the full threshold
      for (int k = 1; k <= DEPTH; k++)
         run(110 + k, ex(ins(n, 6'(40 + k), 32'h0, 32'h0, 1, 50, 0, 0), 0, 0, 0, 0, k, k >= DEPTH - 1));
      run(120, ex(ctl(n, 1, 1, 1), 0, 0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
